// File: rtl/cs42448_tdm_rx_if.sv
// Sample-side bus of the CS42448 TDM receiver: decoded samples, frame strobes and lock status.
// smp_valid, frame_done and frame_err are one-cycle strobes with no back-pressure; the consumer must capture them in the cycle they are high.
interface cs42448_tdm_rx_if #(
    parameter int SAMPLE_BITS = 24,
    parameter int CH_W        = 3
);
    logic [SAMPLE_BITS-1:0] smp_data;
    logic [CH_W-1:0]        smp_ch;
    logic                   smp_valid;
    logic                   frame_done;
    logic                   frame_err;
    logic                   locked;
    logic                   state_dbg;

    modport master (
        output smp_data, smp_ch, smp_valid, frame_done, frame_err, locked, state_dbg
    );

    modport slave (
        input smp_data, smp_ch, smp_valid, frame_done, frame_err, locked, state_dbg
    );
endinterface

// File: rtl/cs42448_tdm_rx.sv
// TDM serial receiver for the CS42448 codec: oversamples SCLK/FS/SDIN in the sys_clk domain,
// locks to frame sync and emits one MSB-first sample per slot.
module cs42448_tdm_rx #(
    parameter int SLOTS       = 8,
    parameter int SLOT_BITS   = 32,
    parameter int SAMPLE_BITS = 24
) (
    input  logic             sys_clk,
    input  logic             sys_nrst,
    input  logic             rx_en,
    input  logic             tdm_sclk,
    input  logic             tdm_fs,
    input  logic             tdm_sdin,
    cs42448_tdm_rx_if.master smp
);
    localparam int CH_W  = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int BIT_W = (SLOT_BITS > 1) ? $clog2(SLOT_BITS) : 1;
    localparam logic [CH_W-1:0]  LAST_SLOT = CH_W'(SLOTS - 1);
    localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(SLOT_BITS - 1);
    localparam logic [BIT_W-1:0] SMP_BIT   = BIT_W'(SAMPLE_BITS - 1);

    typedef enum logic {
        HUNT = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t                 state;
    logic [2:0]             sync1;
    logic [2:0]             sync2;
    logic                   sclk_d;
    logic                   rise_q;
    logic                   fs_q;
    logic                   sdin_q;
    logic                   fs_prev;
    logic [BIT_W-1:0]       bit_idx;
    logic [CH_W-1:0]        slot_idx;
    logic [SAMPLE_BITS-1:0] shift;
    logic [SAMPLE_BITS-1:0] shift_next;
    logic                   fs_edge;
    logic                   last_bit;

    // fs_q/sdin_q come from the same synchronizer sample as the rise, so data and clock stay aligned.
    assign fs_edge    = fs_q & ~fs_prev;
    assign last_bit   = (slot_idx == LAST_SLOT) && (bit_idx == LAST_BIT);
    assign shift_next = {shift[SAMPLE_BITS-2:0], sdin_q};

    assign smp.state_dbg = state;

    always_ff @(posedge sys_clk or negedge sys_nrst) begin
        if (!sys_nrst) begin
            state          <= HUNT;
            sync1          <= '0;
            sync2          <= '0;
            sclk_d         <= 1'b0;
            rise_q         <= 1'b0;
            fs_q           <= 1'b0;
            sdin_q         <= 1'b0;
            fs_prev        <= 1'b0;
            bit_idx        <= '0;
            slot_idx       <= '0;
            shift          <= '0;
            smp.smp_data   <= '0;
            smp.smp_ch     <= '0;
            smp.smp_valid  <= 1'b0;
            smp.frame_done <= 1'b0;
            smp.frame_err  <= 1'b0;
            smp.locked     <= 1'b0;
        end else begin
            sync1  <= {tdm_sclk, tdm_fs, tdm_sdin};
            sync2  <= sync1;
            sclk_d <= sync2[2];
            rise_q <= sync2[2] & ~sclk_d;
            fs_q   <= sync2[1];
            sdin_q <= sync2[0];

            smp.smp_valid  <= 1'b0;
            smp.frame_done <= 1'b0;
            smp.frame_err  <= 1'b0;

            if (rise_q) begin
                fs_prev <= fs_q;
            end

            if (!rx_en) begin
                state      <= HUNT;
                smp.locked <= 1'b0;
                bit_idx    <= '0;
                slot_idx   <= '0;
            end else if (rise_q) begin
                case (state)
                    HUNT: begin
                        // The FS bit itself carries no data; slot 0 MSB arrives on the next rise.
                        if (fs_edge) begin
                            state      <= LOCK;
                            smp.locked <= 1'b1;
                            bit_idx    <= '0;
                            slot_idx   <= '0;
                        end
                    end
                    LOCK: begin
                        shift <= shift_next;
                        if (fs_edge && !last_bit) begin
                            smp.frame_err <= 1'b1;
                            bit_idx       <= '0;
                            slot_idx      <= '0;
                        end else if (!fs_edge && last_bit) begin
                            smp.frame_err <= 1'b1;
                            state         <= HUNT;
                            smp.locked    <= 1'b0;
                            bit_idx       <= '0;
                            slot_idx      <= '0;
                        end else begin
                            if (bit_idx == SMP_BIT) begin
                                smp.smp_valid <= 1'b1;
                                smp.smp_data  <= shift_next;
                                smp.smp_ch    <= slot_idx;
                            end
                            if (last_bit) begin
                                smp.frame_done <= 1'b1;
                                bit_idx        <= '0;
                                slot_idx       <= '0;
                            end else if (bit_idx == LAST_BIT) begin
                                bit_idx  <= '0;
                                slot_idx <= slot_idx + CH_W'(1);
                            end else begin
                                bit_idx <= bit_idx + BIT_W'(1);
                            end
                        end
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end
endmodule

// File: doc/cs42448_tdm_rx.md
CS42448_TDM_RX -- requirements
Module: cs42448_tdm_rx

Interface
REQ-001 Parameter SLOTS, default 8, TDM slots per frame.
REQ-002 Parameter SLOT_BITS, default 32, SCLK periods per slot.
REQ-003 Parameter SAMPLE_BITS, default 24, MSB-first sample bits taken from each slot.
REQ-004 sys_clk  input  1  single block clock; all outputs registered on its rising edge.
REQ-005 sys_nrst  input  1  asynchronous, active-low reset.
REQ-006 rx_en  input  1  receiver enable; low forces HUNT.
REQ-007 tdm_sclk  input  1  serial bit clock, asynchronous to sys_clk.
REQ-008 tdm_fs  input  1  frame sync (LRCK/FS), asynchronous.
REQ-009 tdm_sdin  input  1  serial data, asynchronous.
REQ-010 smp_data  output  SAMPLE_BITS  received sample, MSB first.
REQ-011 smp_ch  output  clog2(SLOTS)  slot index of smp_data.
REQ-012 smp_valid  output  1  one-cycle strobe qualifying smp_data/smp_ch.
REQ-013 frame_done  output  1  one-cycle strobe, complete error-free frame received.
REQ-014 frame_err  output  1  one-cycle strobe, framing error detected.
REQ-015 locked  output  1  high while state is LOCK.

Function
REQ-016 tdm_sclk, tdm_fs and tdm_sdin SHALL each pass through a 2-flop synchronizer; SCLK rise = synced high and previous synced low.
REQ-017 All serial sampling SHALL occur only on detected SCLK rises; fs and sdin values used are those synchronized alongside that sclk sample.
REQ-018 Operating constraint: tdm_sclk high and low phases each ≥ 2 sys_clk periods; faster SCLK is unsupported.
REQ-019 FS edge = fs sampled 1 at the current SCLK rise and 0 at the previous SCLK rise.
REQ-020 States: HUNT, LOCK.
REQ-021 HUNT: no strobes; on an FS edge -> LOCK with bit counter = 0; the MSB of slot 0 is the bit at the next SCLK rise.
REQ-022 LOCK: each SCLK rise shifts sdin into a shift register and increments the bit counter (0..SLOTS*SLOT_BITS-1).
REQ-023 When the in-slot bit index reaches SAMPLE_BITS-1, smp_valid SHALL pulse with the SAMPLE_BITS collected bits and smp_ch = slot index; slot bits SAMPLE_BITS..SLOT_BITS-1 are ignored.
REQ-024 smp_valid/smp_data/smp_ch SHALL update on the 3rd sys_clk edge after the edge that first samples tdm_sclk high for the completing bit (fixed latency).
REQ-025 An FS edge at counter = SLOTS*SLOT_BITS-1 (last bit of slot 7) is the expected sync: that bit is still taken, frame_done pulses, and the counter restarts at 0 on the following rise.
REQ-026 An FS edge at any other count SHALL pulse frame_err, discard the partial frame without further smp_valid for it, and resync with counter = 0; state stays LOCK.
REQ-027 Counter at last bit with no FS edge SHALL pulse frame_err (no frame_done), return to HUNT, and emit nothing further until a new FS edge.
REQ-028 frame_done and frame_err SHALL never be high in the same cycle.
REQ-029 rx_en low SHALL force HUNT on the next sys_clk, clear the counter, suppress all strobes, and leave smp_data holding its last value.
REQ-030 smp_valid SHALL be a single-cycle pulse per sample, regardless of SCLK-to-sys_clk ratio.

Reset
REQ-031 sys_nrst low SHALL asynchronously clear synchronizers, shift register, counter, and state to HUNT.
REQ-032 Output reset values: smp_data = 0, smp_ch = 0, smp_valid = 0, frame_done = 0, frame_err = 0, locked = 0.
REQ-033 Reset release mid-frame SHALL produce no strobes until the next FS edge.

Verification
REQ-034 sys_clk 100 MHz, SCLK 12.288 MHz, FS pulse per 256 bits, slot n data = 0xA5A5A0+n in upper 24 bits, low byte 0xFF -> 8 smp_valid pulses, smp_ch 0..7, smp_data 0xA5A5A0..0xA5A5A7, then frame_done; latency exactly 3 sys_clk.
REQ-035 Two consecutive frames back to back -> 16 samples, 2 frame_done pulses, locked stays 1, frame_err never asserts.
REQ-036 Extra FS edge at bit 100 of a frame -> frame_err pulse, no slot 3..7 samples for that frame, next 256-bit frame decodes all 8 slots correctly.
REQ-037 FS omitted after a frame -> frame_err at bit 255, locked = 0, no smp_valid until next FS edge, then correct lock.
REQ-038 sys_nrst asserted at bit 130 -> all outputs 0 immediately; after release mid-frame no strobes until next FS edge.
REQ-039 rx_en low for 1 µs mid-frame -> locked = 0 next cycle, no strobes; rx_en high -> decoding resumes from next FS edge.
